// File: rtl/uart_ctrl_mq_if.sv
// Register-bus bundle between the Wishbone slave decode and uart_ctrl_mq.
interface uart_ctrl_mq_if;
  logic        i_wb_valid;
  logic [31:0] i_wb_adr;
  logic        i_wb_we;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;

  modport master (output i_wb_valid, i_wb_adr, i_wb_we, i_wb_dat, i_wb_sel,
                  input  o_wb_ack, o_wb_dat);
  modport slave  (input  i_wb_valid, i_wb_adr, i_wb_we, i_wb_dat, i_wb_sel,
                  output o_wb_ack, o_wb_dat);
endinterface

// File: rtl/uart_ctrl_mq.sv
// UART controller: RX/TX FIFOs, RX threshold and character timeout, maskable IRQ.
// TX FSM:
//   state     | meaning
//   IDLE      | waiting for a queued character and an idle uart_tx
//   LAUNCH    | pop head into o_tx_data, pulse o_tx_start
//   WAIT_BUSY | waiting for uart_tx to report busy
//   WAIT_DONE | waiting for uart_tx to finish shifting
module uart_ctrl_mq #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int TO_CHARS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       clk_div,
  uart_ctrl_mq_if.slave     wb,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_frame_err,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  output logic              o_irq
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int TX_CW = TX_AW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;
  tx_state_t tx_st, tx_nxt;

  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [RX_AW-1:0]  rx_wp, rx_rp;
  logic [TX_AW-1:0]  tx_wp, tx_rp;
  logic [RX_CW-1:0]  rx_cnt;
  logic [TX_CW-1:0]  tx_cnt;
  logic [15:0]       rx_thr, thr_new;
  logic [3:0]        irq_en, irq_src;
  logic [31:0]       to_cnt, to_limit, div_eff, off, rdata;
  logic [9:0]        stat;
  logic rx_ovr, ferr, tx_ovf;
  logic fire, wr_fire, rd_fire, stat_wr;
  logic rx_empty, rx_full, tx_empty, tx_full, tx_active;
  logic rx_push_req, rx_push, rx_pop, tx_push_req, tx_push, tx_pop;
  logic rx_thr_hit, rx_timeout;
  logic unused_bits;

  assign unused_bits = ^{wb.i_wb_dat[31:16], wb.i_wb_sel[3:2]};

  assign off     = wb.i_wb_adr - BASE_ADDR;
  assign fire    = wb.i_wb_valid & ~wb.o_wb_ack;
  assign wr_fire = fire & wb.i_wb_we;
  assign rd_fire = fire & ~wb.i_wb_we;
  assign stat_wr = wr_fire & (off == 32'h08) & wb.i_wb_sel[0];

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_CW'(RX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_CW'(TX_DEPTH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign rx_push_req = i_rx_valid & ~i_frame_err;
  assign rx_pop      = rd_fire & (off == 32'h00) & ~rx_empty;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign tx_push_req = wr_fire & (off == 32'h04) & wb.i_wb_sel[0];
  assign tx_pop      = (tx_st == LAUNCH);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_active   = (tx_st != IDLE);

  assign rx_thr_hit = (16'(rx_cnt) >= rx_thr);
  assign div_eff    = (clk_div == '0) ? 32'd1 : clk_div;
  assign to_limit   = 32'(TO_CHARS) * 32'd10 * div_eff;
  assign rx_timeout = (to_cnt == '0) & ~rx_empty & ~rx_thr_hit;

  assign stat = {tx_active, rx_thr_hit, rx_timeout, tx_ovf, ferr, rx_ovr,
                 tx_full, tx_empty, rx_full, rx_empty};
  assign irq_src = {tx_ovf | ferr | rx_ovr, tx_empty & ~tx_active, rx_timeout, rx_thr_hit};

  always_comb begin
    thr_new = {wb.i_wb_sel[1] ? wb.i_wb_dat[15:8] : rx_thr[15:8],
               wb.i_wb_sel[0] ? wb.i_wb_dat[7:0]  : rx_thr[7:0]};
    if (thr_new == '0)
      thr_new = 16'd1;
    else if (thr_new > 16'(RX_DEPTH))
      thr_new = 16'(RX_DEPTH);
  end

  always_comb begin
    rdata = '0;
    case (off)
      32'h00:  rdata = rx_empty ? 32'd0 : 32'(rx_mem[rx_rp]);
      32'h08:  rdata = {22'd0, stat};
      32'h0C:  rdata = {28'd0, irq_en};
      32'h10:  rdata = {16'(tx_cnt), 16'(rx_cnt)};
      32'h14:  rdata = {16'd0, rx_thr};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_dat <= '0;
      irq_en      <= '0;
      rx_thr      <= 16'd1;
      rx_ovr      <= 1'b0;
      ferr        <= 1'b0;
      tx_ovf      <= 1'b0;
      o_irq       <= 1'b0;
    end else begin
      wb.o_wb_ack <= fire;
      if (fire)
        wb.o_wb_dat <= wb.i_wb_we ? 32'd0 : rdata;
      if (wr_fire && off == 32'h0C && wb.i_wb_sel[0])
        irq_en <= wb.i_wb_dat[3:0];
      if (wr_fire && off == 32'h14)
        rx_thr <= thr_new;
      // New events win over a same-cycle write-1-to-clear.
      rx_ovr <= (rx_ovr & ~(stat_wr & wb.i_wb_dat[4])) | (rx_push_req & rx_full & ~rx_pop);
      ferr   <= (ferr   & ~(stat_wr & wb.i_wb_dat[5])) | (i_rx_valid & i_frame_err);
      tx_ovf <= (tx_ovf & ~(stat_wr & wb.i_wb_dat[6])) | (tx_push_req & tx_full & ~tx_pop);
      o_irq  <= |(irq_src & irq_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= i_rx_data;
    if (tx_push) tx_mem[tx_wp] <= wb.i_wb_dat[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      to_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + RX_CW'(rx_push) - RX_CW'(rx_pop);
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + TX_CW'(tx_push) - TX_CW'(tx_pop);
      // Down-counter reloads on any FIFO activity; terminal count 0 means timed out.
      if (rx_empty || rx_push || rx_pop)
        to_cnt <= to_limit;
      else if (to_cnt != '0)
        to_cnt <= to_cnt - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st     <= IDLE;
      o_tx_data <= '0;
    end else begin
      tx_st <= tx_nxt;
      if (tx_st == IDLE && tx_nxt == LAUNCH)
        o_tx_data <= tx_mem[tx_rp];
    end
  end

  always_comb begin
    tx_nxt     = tx_st;
    o_tx_start = 1'b0;
    case (tx_st)
      IDLE:      if (!tx_empty && !i_tx_busy) tx_nxt = LAUNCH;
      LAUNCH: begin
        o_tx_start = 1'b1;
        tx_nxt     = WAIT_BUSY;
      end
      WAIT_BUSY: if (i_tx_busy) tx_nxt = WAIT_DONE;
      WAIT_DONE: if (!i_tx_busy) tx_nxt = IDLE;
      default:   tx_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_ctrl_mq.sv
// Directed bench for uart_ctrl_mq: register vector table plus multi-cycle sequences.
module tb_uart_ctrl_mq;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] clk_div;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start, irq;

  uart_ctrl_mq_if wb();

  uart_ctrl_mq dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .wb(wb),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_frame_err(frame_err),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy), .o_irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int tx_n = 0;
  logic [7:0] tx_log [16];
  logic model_en = 1'b1;

  typedef struct {
    logic        we;
    logic [31:0] off;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the ack edge.
  task automatic wb_xfer(input logic we, input logic [31:0] off, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    bit got = 0;
    wb.i_wb_valid = 1'b1;
    wb.i_wb_adr   = BASE + off;
    wb.i_wb_we    = we;
    wb.i_wb_dat   = wdat;
    wb.i_wb_sel   = sel;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (wb.o_wb_ack) got = 1;
    end
    rdat = wb.o_wb_dat;
    wb.i_wb_valid = 1'b0;
    if (!got) chk("wb_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, off, d, 4'hF, r);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, off, 32'd0, 4'hF, r);
    chk(name, r, exp);
  endtask

  task automatic rx_push(input logic [7:0] d, input logic fe);
    rx_data = d; frame_err = fe; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; frame_err = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (tx_start) n_start++;
  end

  // uart_tx model: 20 busy cycles per character
  initial forever begin
    @(negedge clk);
    if (model_en && tx_start) begin
      tx_log[tx_n[3:0]] = tx_data;
      tx_n++;
      tx_busy = 1'b1;
      repeat (20) @(negedge clk);
      tx_busy = 1'b0;
    end
  end

  initial begin
    logic [31:0] r;
    int rise, snap;
    rst_n = 1'b0; clk_div = 32'd4;
    rx_data = '0; rx_valid = 0; frame_err = 0; tx_busy = 0;
    wb.i_wb_valid = 0; wb.i_wb_adr = '0; wb.i_wb_we = 0; wb.i_wb_dat = '0; wb.i_wb_sel = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_tx_start", {31'd0, tx_start}, 32'd0);

    vecs[0]  = '{0, 32'h08, 32'h0,      4'hF, 32'h5};
    vecs[1]  = '{0, 32'h10, 32'h0,      4'hF, 32'h0};
    vecs[2]  = '{0, 32'h0C, 32'h0,      4'hF, 32'h0};
    vecs[3]  = '{0, 32'h14, 32'h0,      4'hF, 32'h1};
    vecs[4]  = '{1, 32'h14, 32'h0,      4'hF, 32'h0};
    vecs[5]  = '{0, 32'h14, 32'h0,      4'hF, 32'h1};
    vecs[6]  = '{1, 32'h14, 32'h64,     4'hF, 32'h0};
    vecs[7]  = '{0, 32'h14, 32'h0,      4'hF, 32'h8};
    vecs[8]  = '{1, 32'h14, 32'h0703,   4'h1, 32'h0};
    vecs[9]  = '{0, 32'h14, 32'h0,      4'hF, 32'h3};
    vecs[10] = '{1, 32'h14, 32'h0,      4'h2, 32'h0};
    vecs[11] = '{0, 32'h14, 32'h0,      4'hF, 32'h3};
    vecs[12] = '{0, 32'h18, 32'h0,      4'hF, 32'h0};
    vecs[13] = '{1, 32'h18, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[14] = '{1, 32'h0C, 32'hFF,     4'hF, 32'h0};
    vecs[15] = '{0, 32'h0C, 32'h0,      4'hF, 32'hF};
    vecs[16] = '{1, 32'h0C, 32'h0,      4'h0, 32'h0};
    vecs[17] = '{0, 32'h0C, 32'h0,      4'hF, 32'hF};
    vecs[18] = '{1, 32'h0C, 32'h0,      4'hF, 32'h0};
    vecs[19] = '{1, 32'h14, 32'h1,      4'hF, 32'h0};
    for (int i = 0; i < 20; i++) begin
      wb_xfer(vecs[i].we, vecs[i].off, vecs[i].wdat, vecs[i].sel, r);
      if (!vecs[i].we) chk($sformatf("vec%0d", i), r, vecs[i].exp);
    end
    rd_chk("irq_en_after_vecs", 32'h0C, 32'h0);

    // TX ordering
    wr(32'h04, 32'h41); wr(32'h04, 32'h42); wr(32'h04, 32'h43);
    cyc(120);
    chk("tx_starts", n_start, 3);
    chk("tx_char0", {24'd0, tx_log[0]}, 32'h41);
    chk("tx_char1", {24'd0, tx_log[1]}, 32'h42);
    chk("tx_char2", {24'd0, tx_log[2]}, 32'h43);
    rd_chk("tx_done_stat", 32'h08, 32'h005);
    wr(32'h0C, 32'h4);
    cyc(1);
    chk("tx_empty_irq", {31'd0, irq}, 32'd1);
    wr(32'h0C, 32'h0);

    // RX overflow
    for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i), 1'b0);
    rd_chk("ovr_levels", 32'h10, 32'h8);
    rd_chk("ovr_stat", 32'h08, 32'h116);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("ovr_rd%0d", i), 32'h00, 32'h10 + i);
    wr(32'h08, 32'h10);
    rd_chk("ovr_w1c_stat", 32'h08, 32'h005);

    // Threshold interrupt
    wr(32'h14, 32'h3); wr(32'h0C, 32'h1);
    rx_push(8'h01, 0); rx_push(8'h02, 0);
    cyc(2);
    chk("thr_irq_below", {31'd0, irq}, 32'd0);
    rx_push(8'h03, 0);
    chk("thr_irq_latency", {31'd0, irq}, 32'd0);
    cyc(1);
    chk("thr_irq_hit", {31'd0, irq}, 32'd1);
    rd_chk("thr_pop", 32'h00, 32'h01);
    cyc(1);
    chk("thr_irq_drop", {31'd0, irq}, 32'd0);
    rd_chk("thr_drain1", 32'h00, 32'h02);
    rd_chk("thr_drain2", 32'h00, 32'h03);

    // Character timeout: limit 2*10*4 = 80 cycles
    wr(32'h14, 32'h4); wr(32'h0C, 32'h2);
    rx_push(8'h55, 0);
    rise = 0;
    for (int k = 1; k <= 200 && rise == 0; k++) begin
      cyc(1);
      if (irq) rise = k;
    end
    chk("timeout_rise", rise, 81);
    rd_chk("timeout_pop", 32'h00, 32'h55);
    cyc(2);
    chk("timeout_clear", {31'd0, irq}, 32'd0);
    rx_push(8'h61, 0);
    rise = 0;
    for (int k = 1; k <= 49; k++) begin
      cyc(1);
      if (irq && rise == 0) rise = k;
    end
    rx_push(8'h62, 0);
    for (int k = 51; k <= 300 && rise == 0; k++) begin
      cyc(1);
      if (irq) rise = k;
    end
    chk("timeout_restart", rise, 131);
    rd_chk("timeout_drain1", 32'h00, 32'h61);
    rd_chk("timeout_drain2", 32'h00, 32'h62);
    wr(32'h0C, 32'h0); wr(32'h14, 32'h1);

    // Frame error
    rx_push(8'h77, 1'b1);
    rd_chk("ferr_levels", 32'h10, 32'h0);
    rd_chk("ferr_stat", 32'h08, 32'h025);
    wr(32'h08, 32'h20);
    rd_chk("ferr_w1c", 32'h08, 32'h005);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) rx_push(8'h20 + 8'(i), 0);
    wb.i_wb_valid = 1; wb.i_wb_adr = BASE; wb.i_wb_we = 0; wb.i_wb_sel = 4'hF;
    rx_data = 8'h28; rx_valid = 1;
    @(posedge clk); #1;
    rx_valid = 0;
    chk("simul_ack", {31'd0, wb.o_wb_ack}, 32'd1);
    chk("simul_dat", wb.o_wb_dat, 32'h20);
    wb.i_wb_valid = 0;
    rd_chk("simul_levels", 32'h10, 32'h8);
    rd_chk("simul_stat", 32'h08, 32'h106);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("simul_rd%0d", i), 32'h00, 32'h21 + i);
    rd_chk("empty_read", 32'h00, 32'h0);
    rd_chk("empty_levels", 32'h10, 32'h0);

    // TX overflow, then reset during WAIT_DONE
    model_en = 0; tx_busy = 1;
    for (int i = 0; i < 9; i++) wr(32'h04, 32'hA0 + i);
    rd_chk("txovf_levels", 32'h10, 32'h0008_0000);
    rd_chk("txovf_stat", 32'h08, 32'h049);
    wr(32'h08, 32'h40);
    rd_chk("txovf_w1c", 32'h08, 32'h009);
    model_en = 1; tx_busy = 0;
    for (int i = 0; i < 10 && !tx_busy; i++) cyc(1);
    cyc(3);
    rd_chk("wait_done_stat", 32'h08, 32'h201);
    snap = n_start;
    rst_n = 0;
    cyc(2);
    rst_n = 1;
    cyc(1);
    rd_chk("rst_stat", 32'h08, 32'h005);
    rd_chk("rst_levels", 32'h10, 32'h0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
    cyc(60);
    chk("rst_no_launch", n_start, snap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_ctrl_mq.md
Name: uart_ctrl_mq

Overview:
Parametrised successor UART controller with independent RX and TX FIFOs, programmable RX threshold, and an RX character-timeout interrupt. It has a maskable, multi-source interrupt and sticky write-1-to-clear error flags. It sits between the Wishbone slave decode and the uart_rx/uart_tx bit engines. It replaces the single-FIFO controller in the user project.

Parameters:
BASE_ADDR, 32'h3000_0000, register window base; offsets below are relative to it.
DATA_W, 8, character width (5..9).
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2).
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2).
TO_CHARS, 2, RX timeout length in character times.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_div  in  32  clocks per UART bit; a value of 0 is treated as 1
i_wb_valid  in  1  bus request (held until o_wb_ack)
i_wb_adr  in  32  byte address
i_wb_we  in  1  1 = write
i_wb_dat  in  32  write data
i_wb_sel  in  4  byte enables
o_wb_ack  out  1  one-cycle acknowledge
o_wb_dat  out  32  read data, valid with o_wb_ack
i_rx_data  in  DATA_W  received character
i_rx_valid  in  1  one-cycle pulse: i_rx_data complete
i_frame_err  in  1  qualifies i_rx_valid: stop bit bad
o_tx_data  out  DATA_W  character to transmit
o_tx_start  out  1  one-cycle start pulse to uart_tx
i_tx_busy  in  1  uart_tx shifting
o_irq  out  1  registered interrupt, level

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clk is the only clock. Reset values: o_wb_ack=0, o_wb_dat=0, o_tx_data=0, o_tx_start=0, o_irq=0. Reset also empties both FIFOs, sets the TX FSM to IDLE, IRQ_EN=0, RX_THR=1, and clears all sticky flags. Reset mid-transfer discards any in-flight character.
- Bus transaction: o_wb_ack=1 in the cycle after i_wb_valid is seen with ack low; it drops the following cycle. This gives exactly one ack and one side-effect per transaction. Register writes and pops take effect in the ack cycle.
- Registers (offset: meaning):
  - 0x00 RX_DATA (RO): pops the RX FIFO head, zero-extended. Reading when empty returns 0 with no side-effect.
  - 0x04 TX_DATA (WO): pushes i_wb_dat[DATA_W-1:0]; the push requires i_wb_sel[0]. A push while the TX FIFO is full is dropped and sets TX_OVF.
  - 0x08 STAT: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] RX_OVR, [5] FERR, [6] TX_OVF, [7] rx_timeout, [8] rx_thr_hit, [9] tx_active. Bits 4-6 are sticky and clear by writing 1. Reset value 0x0000_0005.
  - 0x0C IRQ_EN (RW, bits [3:0]): [0] rx_thr, [1] rx_timeout, [2] tx_empty&!tx_active, [3] any of bits 4-6.
  - 0x10 LEVELS (RO): [15:0] RX count, [31:16] TX count. Each count is $clog2(DEPTH)+1 bits, zero-extended.
  - 0x14 RX_THR (RW, [15:0]): writing 0 stores 1; writes above RX_DEPTH saturate to RX_DEPTH. Register writes honour i_wb_sel per byte.
  - Unmapped offsets: ack, read 0, writes ignored.
- RX path:
  - On i_rx_valid with !i_frame_err, push i_rx_data.
  - On i_rx_valid with i_frame_err, drop the character and set FERR.
  - A push while full (and no pop in the same cycle) is dropped and sets RX_OVR.
  - A simultaneous push and pop succeeds in all states: the count is unchanged, and when full the new character is accepted.
- RX threshold: rx_thr_hit = (rx_count >= RX_THR), level, combinational into STAT.
- RX timeout:
  - Limit = TO_CHARS*10*clk_div, 32-bit, wrap ignored.
  - The counter clears when the RX FIFO is empty, on any RX push, or on any RX pop; otherwise it increments, saturating at the limit.
  - rx_timeout=1 while counter==limit, rx FIFO non-empty, and rx_thr_hit=0.
- TX FSM:
  - IDLE: if the FIFO is non-empty and !i_tx_busy, go to LAUNCH.
  - LAUNCH (1 cycle): pop the head into o_tx_data; o_tx_start=1; go to WAIT_BUSY.
  - WAIT_BUSY: wait for i_tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for i_tx_busy=0, then go to IDLE.
  - tx_active = (state != IDLE). o_tx_data holds its value until the next LAUNCH.
- o_irq: registered OR of (sources & IRQ_EN); one cycle of latency from the source changing.

Test Plan:
- Reset → STAT=0x0000_0005, LEVELS=0, IRQ_EN=0, RX_THR=1, o_irq=0, o_tx_start=0.
- TX order: write TX_DATA 0x41,0x42,0x43 with the uart_tx model busy for 20 cycles per character → exactly three o_tx_start pulses carrying 0x41, 0x42, 0x43 in order. Then STAT[2]=1, STAT[9]=0, and with IRQ_EN=0x4, o_irq=1.
- RX overflow (RX_DEPTH=8): push 9 characters 0x10..0x18 → LEVELS[15:0]=8, STAT[1]=1, STAT[4]=1. Eight reads return 0x10..0x17. Writing STAT=0x10 clears bit 4.
- Threshold: RX_THR=3, IRQ_EN=0x1; push 2 characters → o_irq=0; push a 3rd → o_irq=1 one cycle later; one read → o_irq=0.
- Timeout: clk_div=4, TO_CHARS=2, RX_THR=4, IRQ_EN=0x2; push 1 character → o_irq rises 81 cycles after the push (80-cycle limit plus one register stage). A second push at cycle 50 restarts the count.
- Frame error plus corners:
  - i_rx_valid with i_frame_err → FIFO unchanged, STAT[5]=1.
  - Simultaneous push and pop when full → count stays 8, no RX_OVR.
  - Reading an empty RX_DATA returns 0.
  - rst_n asserted during WAIT_DONE → FSM in IDLE, FIFOs empty.
